// File: rtl/outputs_drain_if.sv
// Bus between the matrix-output drain and its producer/consumer.
// Handshake rules for every signal on this bus:
//   - row writes: a row is taken on a rising edge where wr_en=1 and wr_ready=1;
//     wr_en while wr_ready=0 is dropped and flagged on overflow for one cycle.
//   - stream: an element moves on a rising edge where out_valid=1 and out_ready=1;
//     while out_valid=1 and out_ready=0, out_data and out_last are held stable.
// state_dbg mirrors the FSM state (0 = FILL, 1 = DRAIN) so checkers can bind to it.
interface outputs_drain_if #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_WIDTH  = 16
);
    logic signed [DATA_WIDTH-1:0] input_data [MATRIX_SIZE];
    logic                         wr_en;
    logic                         wr_ready;
    logic                         transpose;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_valid;
    logic                         out_ready;
    logic                         out_last;
    logic                         overflow;
    logic                         state_dbg;

    // Producer/consumer side (testbench or upstream logic)
    modport master (
        output input_data, wr_en, transpose, out_ready,
        input  wr_ready, out_data, out_valid, out_last, overflow, state_dbg
    );

    // Drain block side
    modport slave (
        input  input_data, wr_en, transpose, out_ready,
        output wr_ready, out_data, out_valid, out_last, overflow, state_dbg
    );
endinterface

// File: rtl/outputs_drain.sv
// Collects an N x N result matrix one row at a time, then streams it out
// element by element in row-major or column-major order.
module outputs_drain #(
    parameter int MATRIX_SIZE = 2,
    parameter int DATA_WIDTH  = 16
) (
    input  logic           clk,
    input  logic           rstn,
    outputs_drain_if.slave bus
);
    localparam int N  = MATRIX_SIZE;
    localparam int IW = $clog2(N);
    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [IW-1:0]                row_cnt_q, row_cnt_d;
    logic [IW-1:0]                r_q, r_d;
    logic [IW-1:0]                c_q, c_d;
    logic                         flag_q, flag_d;
    logic                         overflow_q, overflow_d;
    logic signed [DATA_WIDTH-1:0] mem_q [N][N];
    logic signed [DATA_WIDTH-1:0] mem_d [N][N];

    logic out_valid;
    logic out_last;
    logic xfer;

    // [N-1][N-1] is the final element in both drain orders
    assign out_valid     = (state_q == DRAIN);
    assign out_last      = out_valid && (r_q == LAST) && (c_q == LAST);
    assign xfer          = out_valid && bus.out_ready;

    assign bus.wr_ready  = (state_q == FILL);
    assign bus.out_valid = out_valid;
    assign bus.out_last  = out_last;
    assign bus.out_data  = out_valid ? mem_q[r_q][c_q] : '0;
    assign bus.overflow  = overflow_q;
    assign bus.state_dbg = (state_q == DRAIN);

    // Next-state logic: row capture in FILL, index walk in DRAIN
    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        r_d        = r_q;
        c_d        = c_q;
        flag_d     = flag_q;
        overflow_d = 1'b0;
        mem_d      = mem_q;
        case (state_q)
            FILL: begin
                if (bus.wr_en) begin
                    mem_d[row_cnt_q] = bus.input_data;
                    if (row_cnt_q == LAST) begin
                        // Drain order is frozen here so later transpose
                        // changes cannot disturb the held matrix
                        row_cnt_d = '0;
                        flag_d    = bus.transpose;
                        state_d   = DRAIN;
                    end else begin
                        row_cnt_d = row_cnt_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Writes here are dropped; storage is untouched
                overflow_d = bus.wr_en;
                if (xfer) begin
                    if (out_last) begin
                        r_d     = '0;
                        c_d     = '0;
                        state_d = FILL;
                    end else if (!flag_q) begin
                        if (c_q == LAST) begin
                            c_d = '0;
                            r_d = r_q + 1'b1;
                        end else begin
                            c_d = c_q + 1'b1;
                        end
                    end else begin
                        if (r_q == LAST) begin
                            r_d = '0;
                            c_d = c_q + 1'b1;
                        end else begin
                            r_d = r_q + 1'b1;
                        end
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State and storage registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= FILL;
            row_cnt_q  <= '0;
            r_q        <= '0;
            c_q        <= '0;
            flag_q     <= 1'b0;
            overflow_q <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            r_q        <= r_d;
            c_q        <= c_d;
            flag_q     <= flag_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end
endmodule

// File: tb/tb_outputs_drain.sv
// Self-checking bench for outputs_drain: directed scenarios plus randomized
// matrices scored against an order model built from the matrix contents.
module tb_outputs_drain;
    localparam int N = 2;
    localparam int W = 16;

    typedef logic signed [W-1:0] mat_t [N][N];

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    int vectors     = 0;
    int miscompares = 0;

    logic [W-1:0] exp_q[$];

    // Clock
    always #5 clk = ~clk;

    outputs_drain_if #(.MATRIX_SIZE(N), .DATA_WIDTH(W)) bus ();

    outputs_drain #(.MATRIX_SIZE(N), .DATA_WIDTH(W)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    // Reference model: expected stream order for a matrix
    task automatic build_exp(input mat_t m, input logic tr);
        for (int k = 0; k < N * N; k++) begin
            if (tr) exp_q.push_back(m[k % N][k / N]);
            else    exp_q.push_back(m[k / N][k % N]);
        end
    endtask

    // Driver: write N rows on consecutive cycles; transpose only matters on the last
    task automatic drive_rows(input mat_t m, input logic tr);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            vectors++;
            if (bus.wr_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL fill_hs row %0d: wr_ready=%b out_valid=%b, required 1/0",
                         i, bus.wr_ready, bus.out_valid);
            end
            bus.wr_en      = 1'b1;
            bus.input_data = m[i];
            bus.transpose  = (i == N - 1) ? tr : 1'($urandom_range(0, 1));
        end
        build_exp(m, tr);
    endtask

    // Scoreboard-driven drain: mode 0 ready=1, 1 random, 2 three-cycle stall at element 1
    task automatic drain_and_score(input int mode, input int ovf_at, output int stalls);
        int   cycles;
        int   popped;
        int   stall_left;
        logic stall_done;
        logic ovf_done;
        logic ovf_exp;
        logic ready;
        cycles     = 0;
        popped     = 0;
        stall_left = 0;
        stall_done = 1'b0;
        ovf_done   = 1'b0;
        ovf_exp    = 1'b0;
        stalls     = 0;
        while (exp_q.size() > 0 && cycles < 200) begin
            @(negedge clk);
            cycles++;
            bus.wr_en     = 1'b0;
            bus.transpose = 1'($urandom_range(0, 1));
            vectors++;
            if (bus.out_valid !== 1'b1 || bus.wr_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL drain_hs: out_valid=%b wr_ready=%b, required 1/0",
                         bus.out_valid, bus.wr_ready);
            end
            vectors++;
            if (bus.overflow !== ovf_exp) begin
                miscompares++;
                $display("FAIL overflow: got %b, required %b", bus.overflow, ovf_exp);
            end
            ovf_exp = 1'b0;
            vectors++;
            if (bus.out_data !== exp_q[0] || bus.out_last !== (exp_q.size() == 1)) begin
                miscompares++;
                $display("FAIL stream: data=%0d last=%b, required data=%0d last=%b",
                         bus.out_data, bus.out_last, $signed(exp_q[0]), (exp_q.size() == 1));
            end
            case (mode)
                0: ready = 1'b1;
                1: ready = 1'($urandom_range(0, 1));
                default: begin
                    if (popped == 1 && !stall_done) begin
                        stall_left = 3;
                        stall_done = 1'b1;
                    end
                    ready = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end
            endcase
            if (popped == ovf_at && !ovf_done) begin
                bus.wr_en      = 1'b1;
                bus.input_data = '{default: 16'sd9};
                ovf_exp        = 1'b1;
                ovf_done       = 1'b1;
            end
            bus.out_ready = ready;
            if (ready) begin
                void'(exp_q.pop_front());
                popped++;
            end else begin
                stalls++;
            end
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d elements left, required 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rstn           = 1'b0;
        bus.input_data = '{default: '0};
        bus.transpose  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.wr_en     = 1'($urandom_range(0, 1));
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            vectors++;
            if (bus.wr_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 ||
                bus.overflow !== 1'b0 || bus.out_data !== '0) begin
                miscompares++;
                $display("FAIL reset_outputs: wr_ready=%b valid=%b last=%b ovf=%b data=%0d, required 1/0/0/0/0",
                         bus.wr_ready, bus.out_valid, bus.out_last, bus.overflow, bus.out_data);
            end
        end
        rstn      = 1'b1;
        bus.wr_en = 1'b0;
        @(negedge clk);
        vectors++;
        if (bus.wr_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.state_dbg !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset: wr_ready=%b valid=%b state=%b, required 1/0/0",
                     bus.wr_ready, bus.out_valid, bus.state_dbg);
        end
    endtask

    task automatic test_row_major();
        mat_t m;
        int   st;
        m = '{'{16'sd1, 16'sd2}, '{16'sd3, 16'sd4}};
        drive_rows(m, 1'b0);
        drain_and_score(0, -1, st);
    endtask

    task automatic test_transpose();
        mat_t m;
        int   st;
        m = '{'{16'sd1, 16'sd2}, '{16'sd3, 16'sd4}};
        drive_rows(m, 1'b1);
        drain_and_score(0, -1, st);
    endtask

    task automatic test_backpressure();
        mat_t m;
        int   st;
        m = '{'{16'sd1, 16'sd2}, '{16'sd3, 16'sd4}};
        drive_rows(m, 1'b0);
        drain_and_score(2, -1, st);
        vectors++;
        if (st != 3) begin
            miscompares++;
            $display("FAIL stall_cycles: got %0d, required 3", st);
        end
    endtask

    task automatic test_overflow();
        mat_t m;
        int   st;
        m = '{'{16'sd1, 16'sd2}, '{16'sd3, 16'sd4}};
        drive_rows(m, 1'b0);
        drain_and_score(0, 1, st);
    endtask

    task automatic test_reset_mid_fill();
        mat_t m;
        int   st;
        @(negedge clk);
        bus.wr_en      = 1'b1;
        bus.input_data = '{16'sd100, 16'sd200};
        @(negedge clk);
        rstn      = 1'b0;
        bus.wr_en = 1'b1;
        @(negedge clk);
        rstn      = 1'b1;
        bus.wr_en = 1'b0;
        m = '{'{16'sd11, -16'sd12}, '{16'sd13, 16'sd14}};
        drive_rows(m, 1'b1);
        drain_and_score(0, -1, st);
    endtask

    task automatic test_reset_mid_drain();
        mat_t m;
        int   st;
        m = '{'{16'sd1, 16'sd2}, '{16'sd3, 16'sd4}};
        drive_rows(m, 1'b0);
        @(negedge clk);
        bus.wr_en     = 1'b0;
        bus.out_ready = 1'b1;
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== 16'sd1) begin
            miscompares++;
            $display("FAIL mid_drain_first: valid=%b data=%0d, required 1/1",
                     bus.out_valid, bus.out_data);
        end
        @(negedge clk);
        rstn          = 1'b0;
        bus.wr_en     = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (bus.out_valid !== 1'b0 || bus.wr_ready !== 1'b1 || bus.out_data !== '0 ||
            bus.overflow !== 1'b0 || bus.out_last !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_drain_reset: valid=%b wr_ready=%b data=%0d ovf=%b last=%b, required 0/1/0/0/0",
                     bus.out_valid, bus.wr_ready, bus.out_data, bus.overflow, bus.out_last);
        end
        rstn      = 1'b1;
        bus.wr_en = 1'b0;
        exp_q.delete();
        m = '{'{-16'sd5, 16'sd6}, '{16'sd7, -16'sd8}};
        drive_rows(m, 1'b0);
        drain_and_score(0, -1, st);
    endtask

    task automatic test_signed_extremes();
        mat_t m;
        int   st;
        m = '{'{16'sh8000, 16'sh7fff}, '{16'sh0000, 16'shffff}};
        drive_rows(m, 1'b0);
        drain_and_score(1, -1, st);
    endtask

    task automatic test_back_to_back();
        mat_t m;
        int   st;
        for (int k = 0; k < 3; k++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    m[r][c] = W'($urandom);
            drive_rows(m, 1'(k % 2));
            drain_and_score(0, -1, st);
        end
    endtask

    task automatic test_random();
        mat_t m;
        int   st;
        int   ovf_at;
        for (int k = 0; k < 25; k++) begin
            for (int r = 0; r < N; r++)
                for (int c = 0; c < N; c++)
                    m[r][c] = W'($urandom);
            ovf_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 2)) : -1;
            drive_rows(m, 1'($urandom_range(0, 1)));
            drain_and_score(1, ovf_at, st);
        end
    endtask

    initial begin
        bus.wr_en      = 1'b0;
        bus.out_ready  = 1'b0;
        bus.transpose  = 1'b0;
        bus.input_data = '{default: '0};
        test_reset();
        test_row_major();
        test_transpose();
        test_backpressure();
        test_overflow();
        test_reset_mid_fill();
        test_reset_mid_drain();
        test_signed_extremes();
        test_back_to_back();
        test_random();
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
